// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 640x480@60 VGA scan-out of a synchronously read framebuffer with pixel
// replication. Define VGA_FB_TEST_PATTERN_EN to add a colour-bar test_pattern input.
module vga_fb_scanout #(
   parameter int unsigned COLOR_DEPTH = 3,
   parameter int unsigned SCALE_SHIFT = 0,
   parameter int unsigned nX          = 10 - SCALE_SHIFT,
   parameter int unsigned nY          = 9 - SCALE_SHIFT,
   parameter int unsigned AW          = 19 - 2 * SCALE_SHIFT
) (
   input  logic                   Clock,
   input  logic                   Resetn,
`ifdef VGA_FB_TEST_PATTERN_EN
   input  logic                   test_pattern,
`endif
   output logic                   rd_en,
   output logic [AW-1:0]          rd_addr,
   input  logic [COLOR_DEPTH-1:0] rd_data,
   output logic [7:0]             VGA_R,
   output logic [7:0]             VGA_G,
   output logic [7:0]             VGA_B,
   output logic                   VGA_HS,
   output logic                   VGA_VS,
   output logic                   VGA_BLANK_N,
   output logic                   VGA_SYNC_N,
   output logic                   VGA_CLK,
   output logic                   frame_start
);

   localparam int unsigned   CW        = COLOR_DEPTH / 3;
   localparam logic [9:0]    HLast     = 10'd799;
   localparam logic [9:0]    VLast     = 10'd524;
   localparam logic [9:0]    HSyncLo   = 10'd656;
   localparam logic [9:0]    HSyncHi   = 10'd751;
   localparam logic [9:0]    VSyncLo   = 10'd490;
   localparam logic [9:0]    VSyncHi   = 10'd491;
   localparam logic [nX-1:0] LineWords = nX'(640 >> SCALE_SHIFT);
   localparam logic [nY-1:0] FbRows    = nY'(480 >> SCALE_SHIFT);
   localparam logic [9:0]    VMask     = 10'((1 << SCALE_SHIFT) - 1);

   // MSB-first bit replication of a CW-bit field up to 8 bits.
   function automatic logic [7:0] expand(input logic [CW-1:0] f);
      logic [7:0] o;
      o = '0;
      for (int i = 0; i < 8; i++) o[7-i] = f[CW-1-(i%CW)];
      return o;
   endfunction

   logic          pix_en_q, vga_clk_q;
   logic [9:0]    h_q, v_q, h_d, v_d;
   logic [AW-1:0] row_base_q, row_base_d, rd_addr_q;
   logic          rd_en_q, rd_en_d, rd_pend_q;
   logic          act1_q, hs1_q, vs1_q, first1_q;
   logic          active, hs_d, vs_d;
   logic [nX-1:0] col;
   logic [7:0]    r_q, g_q, b_q, r_d, g_d, b_d;
   logic          hs_q, vs_q, blank_q, fs_q;
`ifdef VGA_FB_TEST_PATTERN_EN
   logic          tp1_q;
   logic [2:0]    bar1_q;
`endif

   always_comb begin
      h_d        = (h_q == HLast) ? 10'd0 : h_q + 10'd1;
      v_d        = v_q;
      row_base_d = row_base_q;
      if (h_q == HLast) begin
         v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
         if (v_q == VLast) begin
            row_base_d = '0;
         end else if ((v_d & VMask) == 10'd0) begin
            // Entering a new framebuffer row: advance the running row*width product.
            row_base_d = row_base_q + AW'(LineWords);
         end
      end

      col    = nX'(h_q >> SCALE_SHIFT);
      active = ((h_q >> SCALE_SHIFT) < 10'(LineWords)) &&
               ((v_q >> SCALE_SHIFT) < 10'(FbRows));
      hs_d   = !((h_q >= HSyncLo) && (h_q <= HSyncHi));
      vs_d   = !((v_q >= VSyncLo) && (v_q <= VSyncHi));
`ifdef VGA_FB_TEST_PATTERN_EN
      rd_en_d = active && !test_pattern;
`else
      rd_en_d = active;
`endif

      // Only data answering a real read is displayed; anything else on rd_data is dropped.
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (rd_pend_q) begin
         r_d = expand(rd_data[COLOR_DEPTH-1 -: CW]);
         g_d = expand(rd_data[2*CW-1 -: CW]);
         b_d = expand(rd_data[CW-1:0]);
      end
`ifdef VGA_FB_TEST_PATTERN_EN
      if (tp1_q) begin
         r_d = act1_q ? {8{bar1_q[2]}} : 8'h00;
         g_d = act1_q ? {8{bar1_q[1]}} : 8'h00;
         b_d = act1_q ? {8{bar1_q[0]}} : 8'h00;
      end
`endif
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         pix_en_q   <= 1'b0;
         vga_clk_q  <= 1'b0;
         h_q        <= '0;
         v_q        <= '0;
         row_base_q <= '0;
         rd_addr_q  <= '0;
         rd_en_q    <= 1'b0;
         rd_pend_q  <= 1'b0;
         act1_q     <= 1'b0;
         hs1_q      <= 1'b1;
         vs1_q      <= 1'b1;
         first1_q   <= 1'b0;
         r_q        <= '0;
         g_q        <= '0;
         b_q        <= '0;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         blank_q    <= 1'b0;
         fs_q       <= 1'b0;
`ifdef VGA_FB_TEST_PATTERN_EN
         tp1_q      <= 1'b0;
         bar1_q     <= '0;
`endif
      end else begin
         pix_en_q  <= ~pix_en_q;
         vga_clk_q <= ~pix_en_q;
         rd_en_q   <= 1'b0;
         rd_pend_q <= rd_en_q;
         fs_q      <= 1'b0;
         if (pix_en_q) begin
            h_q        <= h_d;
            v_q        <= v_d;
            row_base_q <= row_base_d;
            // Stage 1: address and the timing of the pixel being fetched.
            rd_addr_q  <= row_base_q + AW'(col);
            rd_en_q    <= rd_en_d;
            act1_q     <= active;
            hs1_q      <= hs_d;
            vs1_q      <= vs_d;
            first1_q   <= (h_q == 10'd0) && (v_q == 10'd0);
`ifdef VGA_FB_TEST_PATTERN_EN
            tp1_q      <= test_pattern;
            bar1_q     <= h_q[9:7];
`endif
            // Stage 2: colour arrives, timing travels alongside it.
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            hs_q       <= hs1_q;
            vs_q       <= vs1_q;
            blank_q    <= act1_q;
            fs_q       <= first1_q;
         end
      end
   end

   assign rd_en       = rd_en_q;
   assign rd_addr     = rd_addr_q;
   assign VGA_R       = r_q;
   assign VGA_G       = g_q;
   assign VGA_B       = b_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_q;
   assign VGA_SYNC_N  = 1'b0;
   assign VGA_CLK     = vga_clk_q;
   assign frame_start = fs_q;

endmodule
